// File: rtl/id_issue_queue_if.sv
// PC_set packet definition and the ID -> issue handshake bundle shared by the
// issue queue and whatever drives it.
package id_issue_queue_pkg;
   typedef struct packed {
      logic        o_valid;
      logic [31:0] PC;
      logic [31:0] PC_pre;
      logic [31:0] imm;
      logic [13:0] csr_raddr;
      logic [5:0]  ecode;
   } pc_set_t;
endpackage

interface id_issue_queue_if #(
   parameter int DEPTH = 8
);
   import id_issue_queue_pkg::*;

   logic                     flush;
   logic [1:0]               i_valid;
   pc_set_t [1:0]            i_pkt;
   logic                     o_ready;
   logic [1:0]               o_valid;
   pc_set_t [1:0]            o_pkt;
   logic [1:0]               i_pop;
   logic [$clog2(DEPTH):0]   o_count;

   // master: decode/issue side driving the queue; slave: the queue itself
   modport master (
      output flush, i_valid, i_pkt, i_pop,
      input  o_ready, o_valid, o_pkt, o_count
   );

   modport slave (
      input  flush, i_valid, i_pkt, i_pop,
      output o_ready, o_valid, o_pkt, o_count
   );
endinterface

// File: rtl/id_issue_queue.sv
// In-order dual-slot issue queue: compacts up to two decoded packets per cycle
// into a circular buffer and presents the two oldest to the issue stage.
module id_issue_queue
   import id_issue_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   id_issue_queue_if.slave   q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] r_rp;
   logic [PW-1:0] r_wp;
   logic [CW-1:0] r_cnt;
   pc_set_t       r_mem [DEPTH];

   logic          w_ready;
   logic          w_push_en;
   logic          w_wr_both;
   logic          w_wr_one;
   pc_set_t       w_wr_sel;
   logic [PW-1:0] w_wp_inc;
   logic [CW-1:0] w_push_num;
   logic [CW-1:0] w_pop_req;
   logic [CW-1:0] w_pop_num;
   logic [1:0]    w_live;
   pc_set_t       w_rd_pkt [2];

   // Space is judged on the pre-pop count so a same-cycle pop never grants room.
   assign w_ready   = (CW'(DEPTH) - r_cnt) >= CW'(2);
   assign w_push_en = w_ready & ~q.flush;
   assign w_wr_both = w_push_en & (&q.i_valid);
   assign w_wr_one  = w_push_en & (^q.i_valid);
   assign w_wr_sel  = q.i_valid[0] ? q.i_pkt[0] : q.i_pkt[1];
   assign w_wp_inc  = r_wp + PW'(1);

   assign w_push_num = w_wr_both ? CW'(2) : (w_wr_one ? CW'(1) : CW'(0));
   assign w_pop_req  = q.i_pop[1] ? CW'(2) : CW'(q.i_pop[0]);
   assign w_pop_num  = (w_pop_req > r_cnt) ? r_cnt : w_pop_req;

   // Entry storage carries no reset; only pointers define what is live.
   always_ff @(posedge clk) begin
      if (w_wr_both) begin
         r_mem[r_wp]     <= q.i_pkt[0];
         r_mem[w_wp_inc] <= q.i_pkt[1];
      end else if (w_wr_one) begin
         r_mem[r_wp] <= w_wr_sel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rp  <= '0;
         r_wp  <= '0;
         r_cnt <= '0;
      end else if (q.flush) begin
         r_rp  <= '0;
         r_wp  <= '0;
         r_cnt <= '0;
      end else begin
         r_rp  <= r_rp + w_pop_num[PW-1:0];
         r_wp  <= r_wp + w_push_num[PW-1:0];
         r_cnt <= r_cnt + w_push_num - w_pop_num;
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         logic [PW-1:0] w_rd_idx;
         pc_set_t       w_slot;

         assign w_rd_idx   = r_rp + PW'(gi);
         assign w_live[gi] = r_cnt > CW'(gi);

         always_comb begin
            w_slot = r_mem[w_rd_idx];
            if (!w_live[gi]) begin
               w_slot.o_valid = 1'b0;
            end
         end

         assign w_rd_pkt[gi] = w_slot;
      end
   endgenerate

   assign q.o_ready = w_ready;
   assign q.o_valid = w_live;
   assign q.o_pkt   = {w_rd_pkt[1], w_rd_pkt[0]};
   assign q.o_count = r_cnt;

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed plus randomized bench for id_issue_queue, scored against a queue-based
// model of the buffer contents.
module tb_id_issue_queue;
   import id_issue_queue_pkg::*;

   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] next_pc = 32'h1c001000;

   pc_set_t mq[$];

   id_issue_queue_if #(.DEPTH(DEPTH)) bus ();

   id_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .q   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic pc_set_t mk(input logic [31:0] pc);
      pc_set_t p;
      p.o_valid   = 1'b1;
      p.PC        = pc;
      p.PC_pre    = pc + 32'($urandom_range(0, 64) * 4);
      p.imm       = $urandom;
      p.csr_raddr = 14'($urandom);
      p.ecode     = 6'($urandom);
      return p;
   endfunction

   function automatic pc_set_t nxt();
      pc_set_t p = mk(next_pc);
      next_pc = next_pc + 32'd4;
      return p;
   endfunction

   task automatic check_state(input string tag);
      int n = mq.size();
      chk({tag, ".count"}, 128'(bus.o_count), 128'(n));
      chk({tag, ".ready"}, 128'(bus.o_ready), 128'((DEPTH - n) >= 2));
      for (int k = 0; k < 2; k++) begin
         chk({tag, ".valid"}, 128'(bus.o_valid[k]), 128'(n > k));
         if (n > k) chk({tag, ".pkt"}, 128'(bus.o_pkt[k]), 128'(mq[k]));
         else       chk({tag, ".pktv"}, 128'(bus.o_pkt[k].o_valid), 128'(0));
      end
   endtask

   // One clock of stimulus; inputs change 1 time unit after the edge.
   task automatic cyc(input string tag, input logic [1:0] v, input pc_set_t p0, input pc_set_t p1,
                      input logic [1:0] pop, input logic fl);
      int  n   = mq.size();
      bit  rdy = (DEPTH - n) >= 2;
      int  pe;
      bus.i_valid  = v;
      bus.i_pkt[0] = p0;
      bus.i_pkt[1] = p1;
      bus.i_pop    = pop;
      bus.flush    = fl;
      #1;
      chk({tag, ".ready_pre"}, 128'(bus.o_ready), 128'(rdy));
      @(posedge clk);
      if (fl) begin
         mq.delete();
      end else begin
         pe = (pop > 2) ? 2 : int'(pop);
         if (pe > n) pe = n;
         repeat (pe) void'(mq.pop_front());
         if (rdy) begin
            if (v[0]) mq.push_back(p0);
            if (v[1]) mq.push_back(p1);
         end
      end
      #1;
      bus.i_valid = 2'b00;
      bus.i_pop   = 2'b00;
      bus.flush   = 1'b0;
      check_state(tag);
      $display("cyc %-8s v=%b pop=%0d flush=%0d -> count=%0d valid=%b", tag, v, pop, fl,
               bus.o_count, bus.o_valid);
   endtask

   initial begin
      pc_set_t a, b;
      bus.flush   = 1'b0;
      bus.i_valid = 2'b00;
      bus.i_pkt   = '0;
      bus.i_pop   = 2'b00;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Two-wide push appears one cycle later
      cyc("push11", 2'b11, mk(32'h1c000000), mk(32'h1c000004), 2'd0, 1'b0);
      chk("push11.pc0", 128'(bus.o_pkt[0].PC), 128'(32'h1c000000));
      chk("push11.pc1", 128'(bus.o_pkt[1].PC), 128'(32'h1c000004));
      cyc("drain", 2'b00, '0, '0, 2'd2, 1'b0);

      // Only slot 1 valid: compacted to the head
      cyc("push10", 2'b10, mk(32'h1c000fff), mk(32'h1c000010), 2'd0, 1'b0);
      chk("push10.pc0", 128'(bus.o_pkt[0].PC), 128'(32'h1c000010));
      cyc("drain1", 2'b00, '0, '0, 2'd1, 1'b0);

      // Fill to DEPTH-1, refused push, then pop frees space
      repeat (3) cyc("fill", 2'b11, nxt(), nxt(), 2'd0, 1'b0);
      cyc("fill1", 2'b01, nxt(), nxt(), 2'd0, 1'b0);
      chk("full.cnt7", 128'(bus.o_count), 128'(DEPTH - 1));
      cyc("refuse", 2'b11, nxt(), nxt(), 2'd0, 1'b0);
      cyc("pop2", 2'b00, '0, '0, 2'd2, 1'b0);

      // Walk wp to DEPTH-1, then 2-wide push across the wrap
      cyc("flush", 2'b00, '0, '0, 2'd0, 1'b1);
      repeat (DEPTH - 1) cyc("walk", 2'b01, nxt(), nxt(), 2'd1, 1'b0);
      cyc("wrap11", 2'b11, nxt(), nxt(), 2'd0, 1'b0);
      cyc("to4", 2'b01, nxt(), nxt(), 2'd0, 1'b0);
      repeat (10) cyc("steady", 2'b11, nxt(), nxt(), 2'd2, 1'b0);
      chk("steady.cnt4", 128'(bus.o_count), 128'(4));

      // Clamped pop at cnt=1
      repeat (3) cyc("shrink", 2'b00, '0, '0, 2'd1, 1'b0);
      cyc("clamp", 2'b00, '0, '0, 2'd2, 1'b0);
      chk("clamp.cnt0", 128'(bus.o_count), 128'(0));
      cyc("pop3", 2'b01, nxt(), nxt(), 2'd3, 1'b0);
      cyc("clamp3", 2'b00, '0, '0, 2'd3, 1'b0);

      // Flush beats push and pop
      repeat (2) cyc("grow", 2'b11, nxt(), nxt(), 2'd0, 1'b0);
      cyc("grow1", 2'b01, nxt(), nxt(), 2'd0, 1'b0);
      cyc("flushpp", 2'b11, nxt(), nxt(), 2'd1, 1'b1);
      cyc("postfl", 2'b01, mk(32'h1c000100), nxt(), 2'd0, 1'b0);
      chk("postfl.pc0", 128'(bus.o_pkt[0].PC), 128'(32'h1c000100));

      // Asynchronous reset mid-operation, observed between edges
      cyc("prerst", 2'b11, nxt(), nxt(), 2'd0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      mq.delete();
      check_state("asyncrst");
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         a = nxt();
         b = nxt();
         cyc("rand", 2'($urandom), a, b, 2'($urandom), ($urandom_range(0, 31) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
